// File: rtl/host_switch_seq.sv
// host_switch_seq: sequences hot-standby host transfer between CPU A and CPU B
module host_switch_seq #(
  parameter int GUARD_CYC  = 16,
  parameter int SETTLE_CYC = 64,
  parameter int RESET_CYC  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swi_req,
  input  logic       force_req,
  input  logic       force_target,
  input  logic       auto_en,
  input  logic       io_a,
  input  logic       io_b,
  output logic       switch,
  output logic       io_hold,
  output logic       reset_A,
  output logic       reset_B,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] sw_count
);
  typedef enum logic [1:0] {IDLE, HOLD, SETTLE, RESET_OLD} state_t;
  localparam logic [15:0] G_LAST = 16'(GUARD_CYC - 1);
  localparam logic [15:0] S_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] R_LAST = 16'(RESET_CYC - 1);
  state_t      state;
  logic [15:0] cnt;
  logic        target, forced, cur_ok, alt_ok, tgt_ok, auto_req;
  always_comb begin
    cur_ok   = switch ? io_b : io_a;
    alt_ok   = switch ? io_a : io_b;
    tgt_ok   = target ? io_b : io_a;
    auto_req = auto_en && !cur_ok && alt_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      target   <= 1'b0;
      forced   <= 1'b0;
      switch   <= 1'b0;
      io_hold  <= 1'b0;
      reset_A  <= 1'b0;
      reset_B  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      sw_count <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        IDLE: begin
          if (force_req) begin
            if (force_target != switch) begin
              target  <= force_target;
              forced  <= 1'b1;
              state   <= HOLD;
              busy    <= 1'b1;
              io_hold <= 1'b1;
              cnt     <= G_LAST;
            end
          end else if (swi_req || auto_req) begin
            if (!alt_ok) fail <= 1'b1;
            else begin
              target  <= ~switch;
              forced  <= 1'b0;
              state   <= HOLD;
              busy    <= 1'b1;
              io_hold <= 1'b1;
              cnt     <= G_LAST;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            switch <= target;
            state  <= SETTLE;
            cnt    <= S_LAST;
          end else cnt <= cnt - 16'd1;
        end
        SETTLE: begin
          if (cnt == '0) begin
            io_hold <= 1'b0;
            if (tgt_ok || forced) begin
              done     <= 1'b1;
              sw_count <= (sw_count == 8'hff) ? sw_count : sw_count + 8'd1;
              reset_A  <= target;
              reset_B  <= ~target;
              state    <= RESET_OLD;
              cnt      <= R_LAST;
            end else begin
              switch <= ~target;
              fail   <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end else cnt <= cnt - 16'd1;
        end
        default: begin
          if (cnt == '0) begin
            reset_A <= 1'b0;
            reset_B <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else cnt <= cnt - 16'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_host_switch_seq.sv
// tb_host_switch_seq: random and directed check of host_switch_seq against a timeline model
module tb_host_switch_seq;
  localparam int G = 4, S = 8, R = 10;
  logic clk = 0, rst = 1, swi_req = 0, force_req = 0, force_target = 0, auto_en = 0;
  logic io_a = 1, io_b = 1;
  logic switch, io_hold, reset_A, reset_B, busy, done, fail;
  logic [7:0] sw_count;
  int checks = 0, failures = 0;
  int off = -1, m_cnt = 0;
  bit m_sw, m_tgt, m_forced, m_done, m_fail;
  host_switch_seq #(.GUARD_CYC(G), .SETTLE_CYC(S), .RESET_CYC(R)) dut (
    .clk(clk), .rst(rst), .swi_req(swi_req), .force_req(force_req),
    .force_target(force_target), .auto_en(auto_en), .io_a(io_a), .io_b(io_b),
    .switch(switch), .io_hold(io_hold), .reset_A(reset_A), .reset_B(reset_B),
    .busy(busy), .done(done), .fail(fail), .sw_count(sw_count)
  );
  always #5 clk = ~clk;
  task automatic model_edge();
    bit h_cur, h_alt;
    m_done = 0;
    m_fail = 0;
    if (rst) begin
      off = -1;
      m_sw = 0;
      m_cnt = 0;
    end else if (off < 0) begin
      h_cur = m_sw ? io_b : io_a;
      h_alt = m_sw ? io_a : io_b;
      if (force_req) begin
        if (force_target != m_sw) begin
          off = 1;
          m_tgt = force_target;
          m_forced = 1;
        end
      end else if (swi_req || (auto_en && !h_cur && h_alt)) begin
        if (!h_alt) m_fail = 1;
        else begin
          off = 1;
          m_tgt = !m_sw;
          m_forced = 0;
        end
      end
    end else begin
      off++;
      if (off == G + 1) m_sw = m_tgt;
      if (off == G + S + 1) begin
        if (m_forced || (m_tgt ? io_b : io_a)) begin
          m_done = 1;
          m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        end else begin
          m_fail = 1;
          m_sw = !m_tgt;
          off = -1;
        end
      end
      if (off == G + S + R + 1) off = -1;
    end
  endtask
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("switch", {7'd0, switch}, {7'd0, m_sw});
    chk("io_hold", {7'd0, io_hold}, {7'd0, off >= 1 && off <= G + S});
    chk("reset_A", {7'd0, reset_A}, {7'd0, off > G + S && m_tgt});
    chk("reset_B", {7'd0, reset_B}, {7'd0, off > G + S && !m_tgt});
    chk("busy", {7'd0, busy}, {7'd0, off >= 1});
    chk("done", {7'd0, done}, {7'd0, m_done});
    chk("fail", {7'd0, fail}, {7'd0, m_fail});
    chk("sw_count", sw_count, 8'(m_cnt));
    swi_req = 0;
    force_req = 0;
    rst = 0;
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    run(2);
    swi_req = 1;
    run(25);
    chk("s1_final_switch", {7'd0, switch}, 8'd1);
    chk("s1_final_count", sw_count, 8'd1);
    io_a = 0;
    swi_req = 1;
    run(3);
    io_a = 1;
    swi_req = 1;
    run(9);
    io_a = 0;
    run(16);
    chk("s3_reverted", {7'd0, switch}, 8'd1);
    force_req = 1;
    force_target = 0;
    run(25);
    force_req = 1;
    force_target = 0;
    run(3);
    chk("s4_count", sw_count, 8'd2);
    io_b = 1;
    auto_en = 1;
    run(25);
    auto_en = 0;
    io_a = 1;
    chk("s5_auto_switch", {7'd0, switch}, 8'd1);
    swi_req = 1;
    force_req = 1;
    force_target = 0;
    run(6);
    swi_req = 1;
    run(20);
    swi_req = 1;
    run(7);
    rst = 1;
    run(3);
    chk("s6_reset_count", sw_count, 8'd0);
    for (int k = 0; k < 260; k++) begin
      force_req = 1;
      force_target = !m_sw;
      run(23);
    end
    chk("saturated", sw_count, 8'd255);
    for (int i = 0; i < 3000; i++) begin
      swi_req = ($urandom_range(7) == 0);
      force_req = ($urandom_range(15) == 0);
      force_target = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) auto_en = !auto_en;
      if ($urandom_range(9) == 0) io_a = !io_a;
      if ($urandom_range(9) == 0) io_b = !io_b;
      rst = ($urandom_range(299) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/host_switch_seq.md
# host_switch_seq

Sequences the hot-standby host transfer between CPU A and CPU B. It owns the `switch` control that drives every input/output switch instance and the per-CPU reset lines. On a software request, a forced request or a health-based automatic failover, it freezes the switched I/O, flips the host and waits for the new host to prove healthy. It then either resets the demoted CPU or reverts the transfer. It sits between the command decoder and pulse-detection outputs on one side and the I/O switch fabric and reset pins on the other.

## Interface

Parameters:
- `GUARD_CYC`, 16: cycles `io_hold` is asserted before the host flips (1..65535).
- `SETTLE_CYC`, 64: cycles allowed for the new host to show healthy after the flip (1..65535).
- `RESET_CYC`, 1000: width in cycles of the demoted host's reset pulse (1..65535).

Ports:
- `clk`  in  1: system clock. The block uses this single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `swi_req`  in  1: single-cycle request to move the host to the other CPU.
- `force_req`  in  1: single-cycle forced request to move the host to `force_target`, with no health check.
- `force_target`  in  1: target of the forced request, 0 = A, 1 = B. Sampled only with `force_req`.
- `auto_en`  in  1: enables automatic failover.
- `io_a`, `io_b`  in  1 each: filtered health indication of CPU A and CPU B (1 = healthy).
- `switch`  out  1: current host, 0 = A, 1 = B.
- `io_hold`  out  1: freezes the switched I/O during a transfer.
- `reset_A`, `reset_B`  out  1 each: active-high reset request to each CPU.
- `busy`  out  1: high when the block is in any state other than IDLE.
- `done`  out  1: single-cycle pulse on a committed transfer.
- `fail`  out  1: single-cycle pulse on a rejected or reverted transfer.
- `sw_count`  out  8: count of committed transfers, saturates at 255.

## Operation

States: IDLE, HOLD, SETTLE, RESET_OLD. One shared 16-bit down-counter times every state.

Request priority in IDLE: `force_req` > `swi_req` > auto. Auto fires when `auto_en`=1, the current host's health is 0 and the standby's health is 1.

IDLE:
- Forced request with `force_target` == `switch`: ignored, no pulse.
- Forced request to the other CPU: latch target = `force_target`, set forced=1, go to HOLD.
- `swi_req` or auto: target = ~`switch`.
  - Target's health is 0: pulse `fail`, stay in IDLE.
  - Otherwise: set forced=0, go to HOLD.

HOLD:
- `io_hold`=1 for GUARD_CYC cycles.
- On exit, `switch` <= target and go to SETTLE.

SETTLE:
- `io_hold` stays 1 for SETTLE_CYC cycles.
- On the last cycle, sample the target's health:
  - Health is 1, or forced=1: pulse `done`, increment `sw_count` (saturating), go to RESET_OLD.
  - Otherwise: `switch` <= ~target, pulse `fail`, return to IDLE with no reset issued.

RESET_OLD:
- `io_hold`=0.
- Assert reset of the old host (`reset_A` if target=B, else `reset_B`) for RESET_CYC cycles, then go to IDLE.

General rules:
- `swi_req`, `force_req` and auto conditions outside IDLE are dropped, not queued.
- `reset_A` and `reset_B` are never high together.
- `rst` in any state forces IDLE and the reset values on the next edge. Any transfer in progress is abandoned and `switch` returns to A.

## Timing

- Reset values: `switch`=0, `io_hold`=0, `reset_A`=0, `reset_B`=0, `busy`=0, `done`=0, `fail`=0, `sw_count`=0.
- All outputs are registered.
- With the request sampled at cycle 0:
  - HOLD occupies cycles 1..GUARD_CYC.
  - SETTLE occupies cycles GUARD_CYC+1..GUARD_CYC+SETTLE_CYC.
  - RESET_OLD occupies the next RESET_CYC cycles, then IDLE.
- `busy`=1 for the whole transfer, starting at cycle 1.
- `io_hold`=1 over cycles 1..GUARD_CYC+SETTLE_CYC.
- `switch` changes at cycle GUARD_CYC+1.
- `done`, or the revert `fail`, appears at cycle GUARD_CYC+SETTLE_CYC+1. On a revert, `switch` is restored in that same cycle and the block is in IDLE there.
- A rejected request pulses `fail` at cycle 1.
- The earliest a new request is accepted is the first IDLE cycle.

## Test plan

All scenarios use GUARD_CYC=4, SETTLE_CYC=8, RESET_CYC=10.

1. `io_a`=`io_b`=1, `swi_req` at cycle 0 -> `io_hold` high 1..12, `switch`=1 from cycle 5, `done` at 13, `reset_A` high 13..22, `busy` low at 23, `sw_count`=1.
2. `io_b`=0, `swi_req` at cycle 0 -> `fail` at cycle 1, `switch`, `io_hold` and `busy` unchanged at 0.
3. Scenario 1 with `io_b` dropped to 0 at cycle 9 -> `switch` back to 0 at cycle 13, `fail` at 13, `io_hold`=0 from 13, no reset asserted, `sw_count`=0.
4. `force_req` with `force_target`=1 and `io_b`=0 -> transfer commits, `reset_A` high 13..22. Second `force_req` with `force_target`=1 issued once back in IDLE -> ignored, no pulse.
5. `auto_en`=1, `io_a` falls with `io_b`=1 -> sequence runs as in scenario 1. In a separate run, `swi_req` and `force_req` (`force_target`=0) together while `switch`=1 -> force wins. `swi_req` at cycle 6 -> dropped.
6. `rst` at cycle 7 during SETTLE of scenario 1 -> at cycle 8 `switch`=0, `io_hold`=0, `busy`=0, `sw_count`=0.
